pio_multi_shadow: RTL and testbench

- Avalon-MM slave PIO: NUM_CH output channels plus one edge-capturing input port with interrupt.
- Each output channel has a shadow register (CPU-writable) and an active register (drives out_port).
- Shadows are committed to active atomically, so multi-field settings (size, position, colour) change on the same cycle.
- Sits on the system interconnect between the host bridge and display/overlay logic; supersedes single-register output PIOs.

---
 rtl/pio_multi_shadow.sv | 174 +++++++++++++++++
 tb/tb_pio_multi_shadow.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_multi_shadow.sv
// pio_multi_shadow
//   Avalon-MM slave PIO with NUM_CH shadowed output channels and one
//   edge-capturing input port with a level interrupt.
//   The CPU writes shadow registers. A COMMIT strobe copies every shadow into
//   its active register on the same edge, so multi-field settings change
//   together. With AUTO set, a shadow write also goes straight to its active
//   register.
//
// Ports
//   clk, reset         single clock; synchronous active-high reset
//   address            word address (map below)
//   chipselect, read_n, write_n, byteenable, writedata
//                      Avalon-MM slave write/read controls
//   readdata           read data, registered (latency 1), holds when idle
//   in_port            asynchronous inputs, 2-flop synchronized
//   out_port           active registers, channel 0 in the LSBs
//   out_update         one-cycle pulse in the first cycle new actives are visible
//   irq                |(EDGE_CAPTURE & IRQ_MASK), registered
//
// Address map
//   0 CTRL (bit0 AUTO, bit1 COMMIT strobe reads 0) | 1 STATUS | 2 IN_DATA
//   3 EDGE_CAPTURE (w1c) | 4 IRQ_MASK | 8+2c SHADOW[c] | 9+2c ACTIVE[c]
module pio_multi_shadow #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_CH      = 4,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    IN_WIDTH    = 8,
  parameter int                    EDGE_TYPE   = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic                         chipselect,
  input  logic                         read_n,
  input  logic                         write_n,
  input  logic [DATA_WIDTH/8-1:0]      byteenable,
  input  logic [DATA_WIDTH-1:0]        writedata,
  output logic [DATA_WIDTH-1:0]        readdata,
  input  logic [IN_WIDTH-1:0]          in_port,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
  output logic                         out_update,
  output logic                         irq
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN_DATA = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_EDGE    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK    = ADDR_WIDTH'(4);

  logic [DATA_WIDTH-1:0] shadow [NUM_CH];
  logic [DATA_WIDTH-1:0] active [NUM_CH];
  logic [DATA_WIDTH-1:0] merged [NUM_CH];
  logic                  auto_mode;
  logic                  pending;
  logic [IN_WIDTH-1:0]   sync1, sync2, prev;
  logic [IN_WIDTH-1:0]   edge_cap;
  logic [IN_WIDTH-1:0]   irq_mask;
  logic [IN_WIDTH-1:0]   edge_det;
  logic [IN_WIDTH-1:0]   cap_clr;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [NUM_CH-1:0]     shadow_wr;
  logic                  wr_en, rd_en;
  logic                  ctrl_wr, commit, mask_wr, auto_hit;
  logic                  irq_cond;

  assign wr_en    = chipselect && !write_n;
  assign rd_en    = chipselect && !read_n;
  assign ctrl_wr  = wr_en && (address == ADDR_CTRL) && byteenable[0];
  assign commit   = ctrl_wr && writedata[1];
  assign mask_wr  = wr_en && (address == ADDR_MASK);
  assign irq_cond = |(edge_cap & irq_mask);
  assign auto_hit = auto_mode && (|shadow_wr);

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < DATA_WIDTH/8; b++)
      lane_mask[8*b +: 8] = {8{byteenable[b]}};
  end

  always_comb begin
    shadow_wr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_wr[c] = wr_en && (address == ADDR_WIDTH'(8 + 2*c));
      merged[c]    = (shadow[c] & ~lane_mask) | (writedata & lane_mask);
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = prev & ~sync2;
      2:       edge_det = prev ^ sync2;
      default: edge_det = sync2 & ~prev;
    endcase
  end

  assign cap_clr = (wr_en && (address == ADDR_EDGE))
                 ? (writedata[IN_WIDTH-1:0] & lane_mask[IN_WIDTH-1:0]) : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:    rd_mux[0] = auto_mode;
      ADDR_STATUS:  begin
        rd_mux[0] = pending;
        rd_mux[1] = irq_cond;
      end
      ADDR_IN_DATA: rd_mux[IN_WIDTH-1:0] = sync2;
      ADDR_EDGE:    rd_mux[IN_WIDTH-1:0] = edge_cap;
      ADDR_MASK:    rd_mux[IN_WIDTH-1:0] = irq_mask;
      default:      ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (address == ADDR_WIDTH'(8 + 2*c)) rd_mux = shadow[c];
      if (address == ADDR_WIDTH'(9 + 2*c)) rd_mux = active[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= RESET_VALUE;
        active[c] <= RESET_VALUE;
      end
      auto_mode  <= 1'b0;
      pending    <= 1'b0;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      edge_cap   <= '0;
      irq_mask   <= '0;
      readdata   <= '0;
      out_update <= 1'b0;
      irq        <= 1'b0;
    end else begin
      sync1      <= in_port;
      sync2      <= sync1;
      prev       <= sync2;
      // A new edge beats a same-cycle write-1-clear.
      edge_cap   <= (edge_cap & ~cap_clr) | edge_det;
      irq        <= irq_cond;
      out_update <= commit || auto_hit;

      if (ctrl_wr) auto_mode <= writedata[0];
      if (mask_wr)
        irq_mask <= (irq_mask & ~lane_mask[IN_WIDTH-1:0])
                  | (writedata[IN_WIDTH-1:0] & lane_mask[IN_WIDTH-1:0]);

      if (commit) begin
        for (int c = 0; c < NUM_CH; c++) active[c] <= shadow[c];
        pending <= 1'b0;
      end

      // Shadow writes and COMMIT use different addresses, so never collide.
      for (int c = 0; c < NUM_CH; c++) begin
        if (shadow_wr[c]) begin
          shadow[c] <= merged[c];
          if (auto_mode) active[c] <= merged[c];
          else           pending   <= 1'b1;
        end
      end

      if (rd_en) readdata <= rd_mux;
    end
  end

  always_comb begin
    out_port = '0;
    for (int c = 0; c < NUM_CH; c++) out_port[c*DATA_WIDTH +: DATA_WIDTH] = active[c];
  end

endmodule

// File: tb/tb_pio_multi_shadow.sv
// Testbench for pio_multi_shadow: directed scenarios followed by random bus
// and input traffic, each cycle compared against a register-level model.
module tb_pio_multi_shadow;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int AW = 4;
  localparam int IW = 8;
  localparam int ET = 0;
  localparam logic [DW-1:0] RV = '0;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     address;
  logic              chipselect, read_n, write_n;
  logic [DW/8-1:0]   byteenable;
  logic [DW-1:0]     writedata;
  logic [DW-1:0]     readdata;
  logic [IW-1:0]     in_port;
  logic [NC*DW-1:0]  out_port;
  logic              out_update;
  logic              irq;

  always #5 clk = ~clk;

  pio_multi_shadow #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .ADDR_WIDTH(AW), .IN_WIDTH(IW),
    .EDGE_TYPE(ET), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .in_port(in_port),
    .out_port(out_port), .out_update(out_update), .irq(irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register contents plus a history of sampled inputs
  // (smp[0] newest sample, smp[1] the synchronized value, smp[2] the one before).
  logic [DW-1:0] m_sh [NC];
  logic [DW-1:0] m_act [NC];
  logic          m_auto, m_pend, m_upd, m_irq;
  logic [IW-1:0] m_cap, m_mask;
  logic [DW-1:0] m_rd;
  logic [IW-1:0] smp [$];

  function automatic logic [DW-1:0] model_read(input int a);
    logic [DW-1:0] v;
    v = '0;
    case (a)
      0: v[0] = m_auto;
      1: begin v[0] = m_pend; v[1] = |(m_cap & m_mask); end
      2: v[IW-1:0] = smp[1];
      3: v[IW-1:0] = m_cap;
      4: v[IW-1:0] = m_mask;
      default: if (a >= 8 && (a - 8) / 2 < NC)
                 v = (a % 2 == 0) ? m_sh[(a-8)/2] : m_act[(a-8)/2];
    endcase
    return v;
  endfunction

  function automatic void model_edge();
    logic [DW-1:0] lm, rd_next, v;
    logic [IW-1:0] s2, pv, ed, clr;
    logic          wr, rd, irq_next;
    int            a, c;
    a  = int'(address);
    wr = chipselect && !write_n;
    rd = chipselect && !read_n;
    for (int b = 0; b < DW/8; b++) lm[8*b +: 8] = {8{byteenable[b]}};
    rd_next  = rd ? model_read(a) : m_rd;
    s2 = smp[1];
    pv = smp[2];
    ed = (ET == 1) ? (pv & ~s2) : (ET == 2) ? (pv ^ s2) : (s2 & ~pv);
    clr = (wr && a == 3) ? (writedata[IW-1:0] & lm[IW-1:0]) : '0;
    irq_next = |(m_cap & m_mask);
    if (reset) begin
      for (int k = 0; k < NC; k++) begin m_sh[k] = RV; m_act[k] = RV; end
      m_auto = 0; m_pend = 0; m_upd = 0; m_irq = 0;
      m_cap = '0; m_mask = '0; m_rd = '0;
      smp = '{'0, '0, '0};
      return;
    end
    m_rd  = rd_next;
    m_irq = irq_next;
    m_cap = (m_cap & ~clr) | ed;
    smp.push_front(in_port);
    void'(smp.pop_back());
    m_upd = 0;
    if (wr) begin
      if (a == 0 && byteenable[0]) begin
        if (writedata[1]) begin
          for (int k = 0; k < NC; k++) m_act[k] = m_sh[k];
          m_pend = 0;
          m_upd  = 1;
        end
        m_auto = writedata[0];
      end else if (a == 4) begin
        m_mask = (m_mask & ~lm[IW-1:0]) | (writedata[IW-1:0] & lm[IW-1:0]);
      end else if (a >= 8 && a % 2 == 0 && (a - 8) / 2 < NC) begin
        c = (a - 8) / 2;
        v = (m_sh[c] & ~lm) | (writedata & lm);
        m_sh[c] = v;
        if (m_auto) begin m_act[c] = v; m_upd = 1; end
        else m_pend = 1;
      end
    end
  endfunction

  task automatic cyc();
    logic [NC*DW-1:0] eo;
    model_edge();
    @(posedge clk); #1;
    for (int k = 0; k < NC; k++) eo[k*DW +: DW] = m_act[k];
    chk("out_port", out_port, eo);
    chk("out_update", out_update, m_upd);
    chk("irq", irq, m_irq);
    chk("readdata", readdata, m_rd);
    @(negedge clk);
  endtask

  task automatic idle();
    chipselect = 0; read_n = 1; write_n = 1;
  endtask

  task automatic set_bus(input bit w, input bit r, input int a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] b);
    chipselect = w | r; write_n = !w; read_n = !r;
    address = AW'(a); writedata = d; byteenable = b;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] b);
    set_bus(1, 0, a, d, b); cyc(); idle();
  endtask

  task automatic rd(input int a, output logic [DW-1:0] v);
    set_bus(0, 1, a, '0, '0); cyc(); v = readdata; idle();
  endtask

  logic [DW-1:0] v;

  initial begin
    smp = '{'0, '0, '0};
    reset = 1; in_port = '0; address = '0; writedata = '0; byteenable = '0;
    idle();
    @(negedge clk);
    cyc(); cyc();
    reset = 0;
    chk("rst_out_port", out_port, 0);
    chk("rst_irq", irq, 0);
    for (int a = 0; a < 16; a++) begin
      rd(a, v);
      chk("rst_read", v, 0);
    end

    // shadowed commit, AUTO=0
    wr(8, 32'h1234_5678, 4'hF);
    wr(10, 32'h0000_CAFE, 4'hF);
    chk("shadow_no_effect", out_port, 0);
    rd(1, v); chk("status_pending", v, 1);
    set_bus(1, 0, 0, 32'h2, 4'hF); cyc(); idle();
    chk("commit_out_port", out_port, 128'h0000CAFE_12345678);
    chk("commit_pulse", out_update, 1);
    cyc();
    chk("commit_pulse_end", out_update, 0);
    rd(1, v); chk("status_after_commit", v, 0);
    rd(0, v); chk("ctrl_commit_reads0", v, 0);

    // byteenable with AUTO
    wr(0, 32'h1, 4'hF);
    set_bus(1, 0, 12, 32'hAABB_CCDD, 4'b0101); cyc(); idle();
    chk("auto_pulse", out_update, 1);
    rd(13, v); chk("active2_be", v, 32'h00BB_00DD);
    rd(1, v); chk("auto_no_pending", v, 0);

    // read latency
    set_bus(0, 1, 9, '0, '0); cyc();
    chk("lat_first", readdata, 32'h1234_5678);
    set_bus(0, 1, 2, '0, '0); cyc();
    chk("lat_second", readdata, 0);
    set_bus(0, 1, 9, '0, '0); cyc(); idle(); cyc();
    chk("rd_hold", readdata, 32'h1234_5678);

    // edge capture and irq
    wr(4, 32'h1, 4'hF);
    in_port = 8'h01; cyc(); cyc();
    set_bus(0, 1, 3, '0, '0); cyc();
    chk("cap_not_yet", readdata, 0);
    chk("irq_not_yet", irq, 0);
    cyc(); idle();
    chk("cap_third_edge", readdata, 1);
    chk("irq_next_cycle", irq, 1);
    in_port = 8'h03; repeat (4) cyc();
    rd(3, v); chk("cap_bit1", v, 3);
    wr(3, 32'h1, 4'hF); cyc();
    chk("irq_cleared", irq, 0);
    in_port = 8'h02; repeat (4) cyc();
    in_port = 8'h03; repeat (4) cyc();
    in_port = 8'h02; repeat (4) cyc();
    in_port = 8'h03; cyc(); cyc();
    wr(3, 32'h1, 4'hF);
    rd(3, v); chk("set_wins", v, 3);

    // reset during pending commit
    in_port = 8'h00;
    wr(0, 32'h0, 4'hF);
    wr(8, 32'h55, 4'hF);
    reset = 1; set_bus(1, 0, 0, 32'h2, 4'hF); cyc();
    reset = 0; idle();
    chk("rstc_out_port", out_port, 0);
    chk("rstc_no_pulse", out_update, 0);
    cyc();
    chk("rstc_no_pulse2", out_update, 0);
    rd(1, v); chk("rstc_pending", v, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(199) == 0);
      chipselect = ($urandom_range(3) != 0);
      write_n    = 1'($urandom_range(1));
      read_n     = 1'($urandom_range(1));
      address    = AW'($urandom_range(15));
      byteenable = 4'($urandom);
      writedata  = $urandom;
      if ($urandom_range(7) == 0) in_port = IW'($urandom);
      cyc();
    end
    reset = 0; idle(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
